// File: rtl/mips_datapath_memory_arbiter.sv
// mips_datapath_memory_arbiter: shares one memory port between fetch and data; MIPS_DATAPATH_MEMORY_ARBITER_FAIR_EN adds fetch fairness
module mips_datapath_memory_arbiter #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifetch_valid,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_ready,
    output logic [31:0] ifetch_rdata,
    input  logic        data_valid,
    input  logic        data_write,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        data_misaligned,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_byteEnable,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} stateE;
    stateE stateQ, stateD;
    logic isDataQ, writeQ, misQ;
    logic [1:0] sizeQ, offQ;
    logic [3:0] beQ, baseMask, beD;
    logic [31:0] addrQ, wdataQ, rdataQ, wdataD, sizeMask, loadVal;
    logic grantData, grantFetch, fetchFirst, busy, done, mis, noMem, unusedBits;
    assign unusedBits = ^{ifetch_addr[1:0], 1'(FAIR_LIMIT)};
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_FAIR_EN
    localparam int CW = $clog2(FAIR_LIMIT + 1);
    logic [CW-1:0] fairCnt;
    assign fetchFirst = ifetch_valid && fairCnt >= CW'(FAIR_LIMIT);
    always_ff @(posedge clock) begin
        if (reset) fairCnt <= '0;
        else if (grantFetch) fairCnt <= '0;
        else if (grantData && ifetch_valid) fairCnt <= fairCnt + 1'b1;
    end
`else
    assign fetchFirst = 1'b0;
`endif
    always_comb begin
        baseMask = data_size == 2'd1 ? 4'b0001 : data_size == 2'd2 ? 4'b0011 :
                   data_size == 2'd3 ? 4'b1111 : 4'b0000;
        beD = baseMask << data_addr[1:0];
        wdataD = data_wdata << {data_addr[1:0], 3'b000};
        mis = (data_size == 2'd2 && data_addr[0]) || (data_size == 2'd3 && data_addr[1:0] != 2'd0);
        noMem = mis || data_size == 2'd0;
        busy = stateQ == FETCH || stateQ == DATA;
        done = stateQ == DONE;
        grantData = stateQ == IDLE && data_valid && !fetchFirst;
        grantFetch = stateQ == IDLE && ifetch_valid && !grantData;
        stateD = grantData ? (noMem ? DONE : DATA) : grantFetch ? FETCH :
                 busy ? (mem_ack ? DONE : stateQ) : done ? IDLE : stateQ;
        sizeMask = sizeQ == 2'd1 ? 32'h0000_00FF : sizeQ == 2'd2 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        loadVal = (mem_rdata >> {offQ, 3'b000}) & sizeMask;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= IDLE;
            isDataQ <= 1'b0;
            writeQ <= 1'b0;
            misQ <= 1'b0;
            sizeQ <= '0;
            offQ <= '0;
            beQ <= '0;
            addrQ <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
        end else begin
            stateQ <= stateD;
            if (grantData || grantFetch) begin
                isDataQ <= grantData;
                writeQ <= grantData && data_write;
                misQ <= grantData && mis;
                sizeQ <= data_size;
                offQ <= grantData ? data_addr[1:0] : 2'd0;
                beQ <= grantData ? beD : 4'hF;
                wdataQ <= grantData ? wdataD : '0;
                addrQ <= {grantData ? data_addr[31:2] : ifetch_addr[31:2], 2'b00};
                rdataQ <= '0;
            end else if (busy && mem_ack) begin
                rdataQ <= !isDataQ ? mem_rdata : writeQ ? '0 : loadVal;
            end
        end
    end
    // memory-side outputs are gated so they read zero whenever no access is in flight
    assign mem_req = busy;
    assign mem_addr = busy ? addrQ : '0;
    assign mem_write = busy && writeQ;
    assign mem_byteEnable = busy ? beQ : '0;
    assign mem_wdata = busy ? wdataQ : '0;
    assign data_ready = done && isDataQ;
    assign ifetch_ready = done && !isDataQ;
    assign data_rdata = data_ready ? rdataQ : '0;
    assign ifetch_rdata = ifetch_ready ? rdataQ : '0;
    assign data_misaligned = data_ready && misQ;
endmodule
